// File: rtl/mux8way_rr.sv
// 8-to-1 round-robin collecting multiplexer with a single-entry registered output.
// Each output word carries its source channel index so a downstream demux can route replies.
module mux8way_rr #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*WIDTH-1:0] in_data,
    input  logic [7:0]         in_valid,
    output logic [7:0]         in_ready,
    output logic [WIDTH-1:0]   out,
    output logic [2:0]         out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [2:0] ptr;
    logic [2:0] grant;
    logic [2:0] idx;
    logic       found;
    logic       gnt_any;
    logic       load_en;

    // Search ptr, ptr+1, ... ptr+7 (3-bit wrap) and take the first requester.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && in_valid[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    assign gnt_any = |in_valid;
    assign load_en = !out_valid || out_ready;

    // Gated by rst_n so no channel sees an acceptance while reset is held.
    assign in_ready = (rst_n && load_en && gnt_any) ? (8'b1 << grant) : 8'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (load_en) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (gnt_any) begin
                out       <= in_data[grant*WIDTH +: WIDTH];
                out_sel   <= grant;
                out_valid <= 1'b1;
                ptr       <= grant + 3'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux8way_rr.sv
// Self-checking bench for mux8way_rr: table of per-cycle vectors plus hand-written reset sequences.
module tb_mux8way_rr;

    localparam int WIDTH = 16;

    logic               clk;
    logic               rst_n;
    logic [8*WIDTH-1:0] in_data;
    logic [7:0]         in_valid;
    logic [7:0]         in_ready;
    logic [WIDTH-1:0]   out;
    logic [2:0]         out_sel;
    logic               out_valid;
    logic               out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mux8way_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  iv;    // in_valid driven this cycle
        logic        ordy;  // out_ready driven this cycle
        logic [7:0]  ir;    // expected in_ready before the edge
        logic        ov;    // expected out_valid after the edge
        logic [2:0]  sel;   // expected out_sel after the edge
        logic [15:0] dout;  // expected out after the edge
    } vec_t;

    localparam int NVEC = 25;
    vec_t tbl [NVEC];

    function automatic logic [15:0] chan_word(input int i);
        if (i == 3) return 16'hBEEF;
        return 16'h1010 + 16'(i) * 16'h1111;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input int n);
        @(negedge clk);
        in_valid  = tbl[n].iv;
        out_ready = tbl[n].ordy;
        #1;
        check($sformatf("in_ready[%0d]", n), 32'(in_ready), 32'(tbl[n].ir));
        @(posedge clk);
        #1;
        check($sformatf("out_valid[%0d]", n), 32'(out_valid), 32'(tbl[n].ov));
        check($sformatf("out_sel[%0d]", n), 32'(out_sel), 32'(tbl[n].sel));
        check($sformatf("out[%0d]", n), 32'(out), 32'(tbl[n].dout));
    endtask

    initial begin
        // Expected values hand-derived from the round-robin rules, ptr starting at 0.
        tbl[0]  = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000};
        tbl[1]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 16'h1010};
        tbl[2]  = '{8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 16'h2121};
        tbl[3]  = '{8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 16'h3232};
        tbl[4]  = '{8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 16'hBEEF};
        tbl[5]  = '{8'hFF, 1'b1, 8'h10, 1'b1, 3'd4, 16'h5454};
        tbl[6]  = '{8'hFF, 1'b1, 8'h20, 1'b1, 3'd5, 16'h6565};
        tbl[7]  = '{8'hFF, 1'b1, 8'h40, 1'b1, 3'd6, 16'h7676};
        tbl[8]  = '{8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 16'h8787};
        tbl[9]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3'd0, 16'h1010};
        tbl[10] = '{8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 16'h2121};
        // backpressure for three cycles, then same-cycle consume and accept
        tbl[11] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd1, 16'h2121};
        tbl[12] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd1, 16'h2121};
        tbl[13] = '{8'hFF, 1'b0, 8'h00, 1'b1, 3'd1, 16'h2121};
        tbl[14] = '{8'hFF, 1'b1, 8'h04, 1'b1, 3'd2, 16'h3232};
        tbl[15] = '{8'h08, 1'b1, 8'h08, 1'b1, 3'd3, 16'hBEEF};
        // wrap/skip: grant 6, then {0,6} searches 7,0 then 1..6
        tbl[16] = '{8'h40, 1'b1, 8'h40, 1'b1, 3'd6, 16'h7676};
        tbl[17] = '{8'h41, 1'b1, 8'h01, 1'b1, 3'd0, 16'h1010};
        tbl[18] = '{8'h41, 1'b1, 8'h40, 1'b1, 3'd6, 16'h7676};
        // idle drain keeps ptr at 7, next grant goes to 7
        tbl[19] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd6, 16'h7676};
        tbl[20] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd6, 16'h7676};
        tbl[21] = '{8'hFF, 1'b1, 8'h80, 1'b1, 3'd7, 16'h8787};
        tbl[22] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd7, 16'h8787};
        tbl[23] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 16'h8787};
        // empty register loads even with out_ready low
        tbl[24] = '{8'h02, 1'b0, 8'h02, 1'b1, 3'd1, 16'h2121};

        for (int i = 0; i < 8; i++) in_data[i*WIDTH +: WIDTH] = chan_word(i);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out", 32'(out), 32'h0);
        in_valid = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < NVEC; n++) apply(n);

        // Asynchronous reset mid-cycle while a word is held (out_valid=1, out_ready=0).
        check("pre_reset_out_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #3;
        in_valid = 8'hFF;
        rst_n    = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'h0);
        check("async_rst_out_sel", 32'(out_sel), 32'h0);
        check("async_rst_out_valid", 32'(out_valid), 32'h0);
        check("async_rst_in_ready", 32'(in_ready), 32'h0);

        @(negedge clk);
        in_valid  = 8'h00;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_reset_idle_out_valid", 32'(out_valid), 32'h0);
        end

        // ptr cleared by reset: all-valid grants channel 0 first.
        @(negedge clk);
        in_valid = 8'hFF;
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'h01);
        @(posedge clk);
        #1;
        check("post_reset_out_sel", 32'(out_sel), 32'h0);
        check("post_reset_out", 32'(out), 32'h1010);
        check("post_reset_out_valid", 32'(out_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
